cdb_scheduler: RTL and testbench
================================

# cdb_scheduler

Round-robin scheduler for the common data bus in the Tomasulo core. Each functional unit (ALU, multiplier, load unit, divider) posts a finished result (32-bit value plus 4-bit reservation-station label) into a one-entry holding slot. The scheduler picks at most one full slot per cycle and drives the registered broadcast (data, label, enable) seen by reservation stations and the register file. It replaces fixed-priority selection so that no unit can starve another.

## Interface
Parameters:
- NREQ, 4, number of requesting functional units
- DATA_W, 32, result width
- LABEL_W, 4, reservation-station label width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous squash of all pending results (branch mispredict)
- req_valid  input  NREQ  unit i offers a result this cycle
- req_data  input  NREQ*DATA_W  result of unit i at bits [i*DATA_W +: DATA_W]
- req_label  input  NREQ*LABEL_W  label of unit i at bits [i*LABEL_W +: LABEL_W]
- req_ready  output  NREQ  slot i can accept this cycle
- cdb_en  output  1  broadcast valid (registered)
- cdb_data  output  DATA_W  broadcast value (registered)
- cdb_label  output  LABEL_W  broadcast label (registered)
- cdb_grant  output  NREQ  one-hot source of the current broadcast (registered); all zero when cdb_en=0

## Operation
- State: per-slot full[i], data[i], label[i]; round-robin pointer ptr (0..NREQ-1); output registers.
- Pick (combinational): the winner is the first full slot found searching ptr, ptr+1, …, wrapping modulo NREQ. win[i] is one-hot or zero.
- req_ready[i] = ~full[i] | win[i]. It depends only on state, never on req_valid. When a slot is drained and refilled on the same edge, a unit can post one result per cycle.
- Accept: a slot loads on req_valid[i] & req_ready[i]. The new data/label replace the old ones, and full[i] stays 1.
- Drain: a winning slot that is not refilled clears full[i].
- Broadcast: on a cycle with a winner, the next edge loads cdb_data/cdb_label from the winning slot, sets cdb_grant=win, sets cdb_en=1, and sets ptr to (winner+1) mod NREQ.
- No winner: cdb_en←0 and cdb_grant←0. cdb_data/cdb_label hold their last values, and ptr holds.
- flush=1: at the next edge all full[i]←0, cdb_en←0, cdb_grant←0 and ptr←0. Any req_valid in the flush cycle is dropped, and req_ready stays as computed.
- Label 0 carries no special meaning to this block and is broadcast like any other label.
- The block performs no arithmetic except the ptr wrap, which uses NREQ-1 → 0.

## Timing
- Reset values: all full=0, ptr=0, cdb_en=0, cdb_grant=0, cdb_data=0, cdb_label=0. req_ready therefore resets to all ones.
- Latency: a result accepted at edge k into an empty system appears on cdb_* in the cycle after edge k+1 (two edges from offer to broadcast).
- Throughput: one broadcast per cycle while any slot is full.
- Fairness: a full slot is broadcast within NREQ cycles of becoming full.
- Simultaneous accept and drain on the same slot: the old entry is broadcast and the new one is held.
- Reset asserted mid-operation clears everything immediately, without waiting for clk. Pending results are lost.

## Structure
- Shared package holds NREQ, DATA_W, LABEL_W and the one-hot grant type, reused by the functional-unit wrappers.
- One sub-module, rr_pick, a combinational rotate-priority picker. It takes NREQ full bits and ptr and returns a one-hot win.
- Slot storage and output registers stay in cdb_scheduler.

## Test plan
- Reset check: assert rst_n=0 mid-cycle. Required: cdb_en=0, cdb_grant=0, cdb_data=0 and req_ready=4'b1111 immediately.
- Single offer: unit 2 offers 0xDEADBEEF with label 5 at edge k. Required: at edge k+1, cdb_en=1, cdb_data=0xDEADBEEF, cdb_label=5, cdb_grant=4'b0100. At edge k+2, cdb_en=0.
- Round-robin: all four units offer together once (labels 1–4), starting from ptr=0. Required: broadcasts on four consecutive cycles in order 0, 1, 2, 3, then cdb_en=0.
- Pointer wrap: with ptr=3, units 1 and 3 are full. Required: unit 3 is broadcast first and unit 1 second, and ptr ends at 2.
- Back-to-back streaming: unit 0 holds req_valid=1 with data incrementing each cycle while the other units are idle. Required: req_ready[0] stays 1, one broadcast per cycle with no gaps, and the data sequence is preserved.
- Flush: slots 0 and 2 are full, and flush=1 is asserted together with req_valid[1]. Required: at the next edge cdb_en=0 and all slots are empty (unit 1's offer is dropped), ptr=0, and no stale broadcast follows.

Source files
------------

// File: rtl/cdb_scheduler_pkg.sv
// Shared sizing and types for the common-data-bus scheduler and the functional-unit wrappers.
package cdb_scheduler_pkg;

  localparam int NREQ    = 4;
  localparam int DATA_W  = 32;
  localparam int LABEL_W = 4;
  localparam int PTR_W   = $clog2(NREQ);

  typedef logic [NREQ-1:0]  grant_t;
  typedef logic [PTR_W-1:0] ptr_t;

  // Round-robin successor; wraps NREQ-1 back to 0 so non-power-of-two NREQ also works.
  function automatic ptr_t ptr_next(input ptr_t p);
    return (p == ptr_t'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_scheduler_if.sv
// Result-posting handshake from the functional units plus the registered CDB broadcast.
interface cdb_scheduler_if;
  import cdb_scheduler_pkg::*;

  logic                      flush;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ*DATA_W-1:0]    req_data;
  logic [NREQ*LABEL_W-1:0]   req_label;
  logic [NREQ-1:0]           req_ready;
  logic                      cdb_en;
  logic [DATA_W-1:0]         cdb_data;
  logic [LABEL_W-1:0]        cdb_label;
  grant_t                    cdb_grant;

  modport master (
    output flush, req_valid, req_data, req_label,
    input  req_ready, cdb_en, cdb_data, cdb_label, cdb_grant
  );

  modport slave (
    input  flush, req_valid, req_data, req_label,
    output req_ready, cdb_en, cdb_data, cdb_label, cdb_grant
  );

endinterface

// File: rtl/cdb_scheduler_rr_pick.sv
// Rotate-priority picker: first full slot at or after the pointer, wrapping, as a one-hot win.
module rr_pick
  import cdb_scheduler_pkg::*;
(
  input  grant_t i_full,
  input  ptr_t   i_ptr,
  output grant_t o_win
);

  logic w_found;
  ptr_t w_idx;

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    o_win   = '0;
    w_found = 1'b0;
    w_idx   = i_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && i_full[w_idx]) begin
        o_win[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
      w_idx = ptr_next(w_idx);
    end
  end

endmodule

// File: rtl/cdb_scheduler.sv
// Round-robin CDB scheduler: one holding slot per functional unit, one registered broadcast per cycle.
module cdb_scheduler
  import cdb_scheduler_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  cdb_scheduler_if.slave  bus
);

  grant_t              r_full;
  logic [DATA_W-1:0]   r_data  [NREQ];
  logic [LABEL_W-1:0]  r_label [NREQ];
  ptr_t                r_ptr;

  logic                r_cdb_en;
  logic [DATA_W-1:0]   r_cdb_data;
  logic [LABEL_W-1:0]  r_cdb_label;
  grant_t              r_cdb_grant;

  grant_t              w_win;
  grant_t              w_ready;
  grant_t              w_accept;
  logic                w_any;
  ptr_t                w_win_idx;
  logic [DATA_W-1:0]   w_win_data;
  logic [LABEL_W-1:0]  w_win_label;

  rr_pick u_pick (
    .i_full (r_full),
    .i_ptr  (r_ptr),
    .o_win  (w_win)
  );

  // A winning slot frees up this cycle, so it may be refilled on the same edge it drains.
  assign w_ready  = ~r_full | w_win;
  assign w_accept = bus.req_valid & w_ready & {NREQ{~bus.flush}};
  assign w_any    = |w_win;

  always_comb begin
    w_win_idx   = '0;
    w_win_data  = '0;
    w_win_label = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) begin
        w_win_idx   = ptr_t'(i);
        w_win_data  = r_data[i];
        w_win_label = r_label[i];
      end
    end
  end

  // NOTE: slot payload has no reset; it is only ever read while its full bit is set, and full is reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (w_accept[i]) begin
        r_data[i]  <= bus.req_data[i*DATA_W +: DATA_W];
        r_label[i] <= bus.req_label[i*LABEL_W +: LABEL_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
    end else if (bus.flush) begin
      r_full <= '0;
    end else begin
      r_full <= w_accept | (r_full & ~w_win);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_cdb_en    <= 1'b0;
      r_cdb_grant <= '0;
      r_cdb_data  <= '0;
      r_cdb_label <= '0;
    end else if (bus.flush) begin
      r_ptr       <= '0;
      r_cdb_en    <= 1'b0;
      r_cdb_grant <= '0;
    end else if (w_any) begin
      r_ptr       <= ptr_next(w_win_idx);
      r_cdb_en    <= 1'b1;
      r_cdb_grant <= w_win;
      r_cdb_data  <= w_win_data;
      r_cdb_label <= w_win_label;
    end else begin
      r_cdb_en    <= 1'b0;
      r_cdb_grant <= '0;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.cdb_en    = r_cdb_en;
  assign bus.cdb_data  = r_cdb_data;
  assign bus.cdb_label = r_cdb_label;
  assign bus.cdb_grant = r_cdb_grant;

endmodule

// File: tb/tb_cdb_scheduler.sv
// Scoreboard bench for cdb_scheduler: scenarios push expected broadcasts, a negedge monitor pops and compares.
module tb_cdb_scheduler;
  import cdb_scheduler_pkg::*;

  typedef struct {
    logic [DATA_W-1:0]  data;
    logic [LABEL_W-1:0] label;
    grant_t             grant;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;

  cdb_scheduler_if bus();

  cdb_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Monitor: every broadcast must match the oldest expected entry; idle cycles must carry no grant.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (bus.cdb_en === 1'b1) begin
        n_checks++;
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_bcast: got data=%h label=%h grant=%b, required no broadcast",
                   bus.cdb_data, bus.cdb_label, bus.cdb_grant);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (bus.cdb_data !== e.data || bus.cdb_label !== e.label || bus.cdb_grant !== e.grant) begin
            n_errors++;
            $display("FAIL bcast: got data=%h label=%h grant=%b, required data=%h label=%h grant=%b",
                     bus.cdb_data, bus.cdb_label, bus.cdb_grant, e.data, e.label, e.grant);
          end
        end
      end else begin
        n_checks++;
        if (bus.cdb_grant !== '0) begin
          n_errors++;
          $display("FAIL idle_grant: got %b, required 0000", bus.cdb_grant);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush     = 1'b0;
    bus.req_valid = '0;
  endtask

  task automatic offer(input int u, input logic [DATA_W-1:0] d, input logic [LABEL_W-1:0] l);
    bus.req_valid[u]                   = 1'b1;
    bus.req_data[u*DATA_W +: DATA_W]   = d;
    bus.req_label[u*LABEL_W +: LABEL_W] = l;
  endtask

  task automatic expect_bcast(input int u, input logic [DATA_W-1:0] d, input logic [LABEL_W-1:0] l);
    exp_t   e;
    grant_t g;
    g       = '0;
    g[u]    = 1'b1;
    e.data  = d;
    e.label = l;
    e.grant = g;
    q.push_back(e);
  endtask

  task automatic expect_en(input string name, input logic en);
    n_checks++;
    if (bus.cdb_en !== en) begin
      n_errors++;
      $display("FAIL %s: cdb_en got %b, required %b", name, bus.cdb_en, en);
    end
  endtask

  task automatic expect_grant(input string name, input grant_t g);
    n_checks++;
    if (bus.cdb_en !== 1'b1 || bus.cdb_grant !== g) begin
      n_errors++;
      $display("FAIL %s: cdb_en=%b grant=%b, required cdb_en=1 grant=%b", name, bus.cdb_en, bus.cdb_grant, g);
    end
  endtask

  task automatic expect_drained(input string name);
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL %s: %0d expected broadcasts never seen, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.req_data  = '0;
    bus.req_label = '0;
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (bus.cdb_en !== 1'b0 || bus.cdb_grant !== '0 || bus.cdb_data !== '0 ||
        bus.cdb_label !== '0 || bus.req_ready !== 4'b1111) begin
      n_errors++;
      $display("FAIL reset_values: en=%b grant=%b data=%h label=%h ready=%b, required 0 0000 0 0 1111",
               bus.cdb_en, bus.cdb_grant, bus.cdb_data, bus.cdb_label, bus.req_ready);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();
    expect_en("after_reset_idle", 1'b0);
  endtask

  task automatic test_round_robin();
    for (int u = 0; u < NREQ; u++) begin
      offer(u, 32'h1000_0000 + u, LABEL_W'(u + 1));
      expect_bcast(u, 32'h1000_0000 + u, LABEL_W'(u + 1));
    end
    step();
    idle_inputs();
    for (int c = 0; c < NREQ; c++) begin
      step();
      expect_en("rr_consecutive", 1'b1);
    end
    step();
    expect_en("rr_done", 1'b0);
    expect_drained("rr_drain");
  endtask

  task automatic test_single();
    offer(2, 32'hDEAD_BEEF, 4'd5);
    expect_bcast(2, 32'hDEAD_BEEF, 4'd5);
    step();
    idle_inputs();
    step();
    n_checks++;
    if (bus.cdb_en !== 1'b1 || bus.cdb_data !== 32'hDEAD_BEEF || bus.cdb_label !== 4'd5 ||
        bus.cdb_grant !== 4'b0100) begin
      n_errors++;
      $display("FAIL single_bcast: en=%b data=%h label=%h grant=%b, required 1 deadbeef 5 0100",
               bus.cdb_en, bus.cdb_data, bus.cdb_label, bus.cdb_grant);
    end
    step();
    expect_en("single_done", 1'b0);
    expect_drained("single_drain");
  endtask

  // Pointer is 3 after the single-offer test; second pair only orders 2-before-1 if ptr ended at 2.
  task automatic test_ptr_wrap();
    offer(1, 32'h0000_0011, 4'd7);
    offer(3, 32'h0000_0033, 4'd0);
    expect_bcast(3, 32'h0000_0033, 4'd0);
    expect_bcast(1, 32'h0000_0011, 4'd7);
    step();
    idle_inputs();
    step();
    expect_grant("wrap_first", 4'b1000);
    step();
    expect_grant("wrap_second", 4'b0010);
    step();
    expect_en("wrap_done", 1'b0);
    offer(1, 32'h0000_0111, 4'd8);
    offer(2, 32'h0000_0222, 4'd9);
    expect_bcast(2, 32'h0000_0222, 4'd9);
    expect_bcast(1, 32'h0000_0111, 4'd8);
    step();
    idle_inputs();
    step();
    expect_grant("ptr_is_2_first", 4'b0100);
    step();
    expect_grant("ptr_is_2_second", 4'b0010);
    step();
    expect_en("ptr_check_done", 1'b0);
    expect_drained("wrap_drain");
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 8; j++) begin
      offer(0, 32'hC0DE_0000 + j, LABEL_W'(j));
      expect_bcast(0, 32'hC0DE_0000 + j, LABEL_W'(j));
      n_checks++;
      if (bus.req_ready[0] !== 1'b1) begin
        n_errors++;
        $display("FAIL stream_ready: cycle %0d req_ready[0] got %b, required 1", j, bus.req_ready[0]);
      end
      if (j >= 2) expect_en("stream_no_gap", 1'b1);
      step();
    end
    idle_inputs();
    expect_en("stream_tail0", 1'b1);
    step();
    expect_en("stream_tail1", 1'b1);
    step();
    expect_en("stream_done", 1'b0);
    expect_drained("stream_drain");
  endtask

  task automatic test_flush();
    offer(0, 32'h0000_00F0, 4'd1);
    offer(2, 32'h0000_00F2, 4'd2);
    step();
    idle_inputs();
    bus.flush = 1'b1;
    offer(1, 32'h0000_00F1, 4'd3);
    #0;
    n_checks++;
    if (bus.req_ready !== 4'b1110) begin
      n_errors++;
      $display("FAIL flush_ready: got %b, required 1110", bus.req_ready);
    end
    step();
    idle_inputs();
    n_checks++;
    if (bus.cdb_en !== 1'b0 || bus.cdb_grant !== '0 || bus.req_ready !== 4'b1111) begin
      n_errors++;
      $display("FAIL flush_clear: en=%b grant=%b ready=%b, required 0 0000 1111",
               bus.cdb_en, bus.cdb_grant, bus.req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      expect_en("flush_no_stale", 1'b0);
    end
    offer(0, 32'h0000_0A00, 4'd4);
    offer(1, 32'h0000_0A01, 4'd5);
    expect_bcast(0, 32'h0000_0A00, 4'd4);
    expect_bcast(1, 32'h0000_0A01, 4'd5);
    step();
    idle_inputs();
    step();
    expect_grant("flush_ptr0_first", 4'b0001);
    step();
    expect_grant("flush_ptr0_second", 4'b0010);
    step();
    expect_en("flush_post_done", 1'b0);
    expect_drained("flush_drain");
  endtask

  task automatic test_reset_mid();
    mon_en = 1'b0;
    offer(0, 32'h0000_B000, 4'd1);
    offer(1, 32'h0000_B001, 4'd2);
    offer(2, 32'h0000_B002, 4'd3);
    step();
    idle_inputs();
    step();
    expect_en("pre_reset_active", 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.cdb_en !== 1'b0 || bus.cdb_grant !== '0 || bus.cdb_data !== '0 ||
        bus.cdb_label !== '0 || bus.req_ready !== 4'b1111) begin
      n_errors++;
      $display("FAIL mid_reset: en=%b grant=%b data=%h label=%h ready=%b, required 0 0000 0 0 1111",
               bus.cdb_en, bus.cdb_grant, bus.cdb_data, bus.cdb_label, bus.req_ready);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      expect_en("post_reset_lost", 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_ptr_wrap();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
